// File: rtl/pixel_sequencer_pkg.sv
// Shared definitions for the pixel sequencer front end.
//   PIXEL_SIZE / LOC_SIZE : widths of the pixel bus and of the x/y coordinates
//   *_DEF                 : default frame geometry used when the top is not overridden
//   seq_state_e           : sequencer state encoding (IDLE, STREAM, FLUSH)
package pixel_sequencer_pkg;

    localparam int PIXEL_SIZE       = 24;
    localparam int LOC_SIZE         = 10;
    localparam int FRAME_WIDTH_DEF  = 640;
    localparam int FRAME_HEIGHT_DEF = 480;
    localparam int FLUSH_CYCLES_DEF = 2 * FRAME_WIDTH_DEF + 16;
    localparam int CNT_WIDTH_DEF    = 16;

    typedef enum logic [1:0] {
        SEQ_IDLE   = 2'd0,
        SEQ_STREAM = 2'd1,
        SEQ_FLUSH  = 2'd2
    } seq_state_e;

endpackage

// File: rtl/pixel_sequencer_xy_counter.sv
// Raster-order coordinate counter.
//   clk, reset_n : clock, asynchronous active-low reset
//   clr          : treat the current position as (0,0) this cycle
//   inc          : advance one pixel in raster order (applied after clr)
//   x, y         : registered current position
//   last         : the position being consumed this cycle (after clr) is the
//                  final pixel of the frame
module xy_counter
    import pixel_sequencer_pkg::*;
#(
    parameter int FRAME_WIDTH  = FRAME_WIDTH_DEF,
    parameter int FRAME_HEIGHT = FRAME_HEIGHT_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clr,
    input  logic                inc,
    output logic [LOC_SIZE-1:0] x,
    output logic [LOC_SIZE-1:0] y,
    output logic                last
);

    localparam logic [LOC_SIZE-1:0] X_MAX = LOC_SIZE'(FRAME_WIDTH - 1);
    localparam logic [LOC_SIZE-1:0] Y_MAX = LOC_SIZE'(FRAME_HEIGHT - 1);

    logic [LOC_SIZE-1:0] x_q, x_d;
    logic [LOC_SIZE-1:0] y_q, y_d;
    logic [LOC_SIZE-1:0] base_x, base_y;

    always_comb begin
        base_x = clr ? '0 : x_q;
        base_y = clr ? '0 : y_q;
        x_d    = base_x;
        y_d    = base_y;
        if (inc) begin
            if (base_x == X_MAX) begin
                x_d = '0;
                // Wrapping y after the final pixel leaves the counter at (0,0)
                // ready for the next frame without an explicit clear.
                y_d = (base_y == Y_MAX) ? '0 : base_y + 1'b1;
            end else begin
                x_d = base_x + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign last = (base_x == X_MAX) && (base_y == Y_MAX);

endmodule

// File: rtl/pixel_sequencer.sv
// Front end of the vision pipeline: turns a valid/ready RGB pixel stream with
// start-of-frame marking into registered en/x/y/data drive, then appends
// FLUSH_CYCLES zero pixels so line buffers drain before the next frame.
//   s_valid/s_sof/s_data/s_ready : upstream handshake (s_sof marks pixel (0,0))
//   en/x/y/data                  : pipeline drive, registered, one cycle after accept
//   frame_busy                   : sequencer is not idle
//   frame_done                   : pulse on the final flush beat
//   sync_err                     : pulse on a framing error (missing or early sof)
//   frame_count                  : completed frames, wrapping
module pixel_sequencer
    import pixel_sequencer_pkg::*;
#(
    parameter int FRAME_WIDTH  = FRAME_WIDTH_DEF,
    parameter int FRAME_HEIGHT = FRAME_HEIGHT_DEF,
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
    parameter int CNT_WIDTH    = CNT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  s_valid,
    input  logic                  s_sof,
    input  logic [PIXEL_SIZE-1:0] s_data,
    output logic                  s_ready,
    output logic                  en,
    output logic [LOC_SIZE-1:0]   x,
    output logic [LOC_SIZE-1:0]   y,
    output logic [PIXEL_SIZE-1:0] data,
    output logic                  frame_busy,
    output logic                  frame_done,
    output logic                  sync_err,
    output logic [CNT_WIDTH-1:0]  frame_count
);

    localparam logic [LOC_SIZE-1:0]  X_MAX      = LOC_SIZE'(FRAME_WIDTH - 1);
    localparam logic [LOC_SIZE-1:0]  Y_MAX      = LOC_SIZE'(FRAME_HEIGHT - 1);
    localparam logic [CNT_WIDTH-1:0] FLUSH_LOAD = CNT_WIDTH'(FLUSH_CYCLES);
    localparam logic [CNT_WIDTH-1:0] FLUSH_ONE  = CNT_WIDTH'(1);

    seq_state_e              state_q, state_d;
    logic [CNT_WIDTH-1:0]    flush_cnt_q, flush_cnt_d;
    logic [CNT_WIDTH-1:0]    frame_count_q, frame_count_d;
    logic                    en_q, en_d;
    logic [LOC_SIZE-1:0]     x_q, x_d;
    logic [LOC_SIZE-1:0]     y_q, y_d;
    logic [PIXEL_SIZE-1:0]   data_q, data_d;
    logic                    frame_done_q, frame_done_d;
    logic                    sync_err_q, sync_err_d;

    logic                    accept;
    logic                    cnt_clr, cnt_inc, cnt_last;
    logic [LOC_SIZE-1:0]     cnt_x, cnt_y;

    xy_counter #(
        .FRAME_WIDTH  (FRAME_WIDTH),
        .FRAME_HEIGHT (FRAME_HEIGHT)
    ) u_xy_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (cnt_clr),
        .inc     (cnt_inc),
        .x       (cnt_x),
        .y       (cnt_y),
        .last    (cnt_last)
    );

    assign s_ready = (state_q != SEQ_FLUSH);
    assign accept  = s_valid && s_ready;

    always_comb begin
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        frame_count_d = frame_count_q;
        en_d          = 1'b0;
        x_d           = x_q;
        y_d           = y_q;
        data_d        = data_q;
        frame_done_d  = 1'b0;
        sync_err_d    = 1'b0;
        cnt_clr       = 1'b0;
        cnt_inc       = 1'b0;

        case (state_q)
            SEQ_IDLE: begin
                if (accept) begin
                    if (s_sof) begin
                        cnt_clr = 1'b1;
                        cnt_inc = 1'b1;
                        en_d    = 1'b1;
                        data_d  = s_data;
                        x_d     = '0;
                        y_d     = '0;
                        if (cnt_last) begin
                            state_d     = SEQ_FLUSH;
                            flush_cnt_d = FLUSH_LOAD;
                        end else begin
                            state_d = SEQ_STREAM;
                        end
                    end else begin
                        // Mid-frame pixel with no frame in progress: discard.
                        sync_err_d = 1'b1;
                    end
                end
            end
            SEQ_STREAM: begin
                if (accept) begin
                    // An early sof restarts the raster without flushing.
                    cnt_clr    = s_sof;
                    cnt_inc    = 1'b1;
                    sync_err_d = s_sof;
                    en_d       = 1'b1;
                    data_d     = s_data;
                    x_d        = s_sof ? '0 : cnt_x;
                    y_d        = s_sof ? '0 : cnt_y;
                    if (cnt_last) begin
                        state_d     = SEQ_FLUSH;
                        flush_cnt_d = FLUSH_LOAD;
                    end
                end
            end
            SEQ_FLUSH: begin
                en_d        = 1'b1;
                data_d      = '0;
                x_d         = X_MAX;
                y_d         = Y_MAX;
                flush_cnt_d = flush_cnt_q - 1'b1;
                if (flush_cnt_q == FLUSH_ONE) begin
                    frame_done_d  = 1'b1;
                    frame_count_d = frame_count_q + 1'b1;
                    state_d       = SEQ_IDLE;
                end
            end
            default: begin
                state_d = SEQ_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= SEQ_IDLE;
            flush_cnt_q   <= '0;
            frame_count_q <= '0;
            en_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            data_q        <= '0;
            frame_done_q  <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            frame_count_q <= frame_count_d;
            en_q          <= en_d;
            x_q           <= x_d;
            y_q           <= y_d;
            data_q        <= data_d;
            frame_done_q  <= frame_done_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign en          = en_q;
    assign x           = x_q;
    assign y           = y_q;
    assign data        = data_q;
    assign frame_busy  = (state_q != SEQ_IDLE);
    assign frame_done  = frame_done_q;
    assign sync_err    = sync_err_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_pixel_sequencer.sv
// Scoreboard bench for pixel_sequencer with a 4x3 frame and 5 flush beats.
module tb_pixel_sequencer;
    import pixel_sequencer_pkg::*;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int FL = 5;
    localparam int CW = 16;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic                  s_valid;
    logic                  s_sof;
    logic [PIXEL_SIZE-1:0] s_data;
    logic                  s_ready;
    logic                  en;
    logic [LOC_SIZE-1:0]   x;
    logic [LOC_SIZE-1:0]   y;
    logic [PIXEL_SIZE-1:0] data;
    logic                  frame_busy;
    logic                  frame_done;
    logic                  sync_err;
    logic [CW-1:0]         frame_count;

    always #5 clk = ~clk;

    pixel_sequencer #(
        .FRAME_WIDTH  (W),
        .FRAME_HEIGHT (H),
        .FLUSH_CYCLES (FL),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .s_valid     (s_valid),
        .s_sof       (s_sof),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .en          (en),
        .x           (x),
        .y           (y),
        .data        (data),
        .frame_busy  (frame_busy),
        .frame_done  (frame_done),
        .sync_err    (sync_err),
        .frame_count (frame_count)
    );

    typedef struct packed {
        logic [LOC_SIZE-1:0]   x;
        logic [LOC_SIZE-1:0]   y;
        logic [PIXEL_SIZE-1:0] d;
        logic                  done;
    } exp_t;

    exp_t sb[$];

    int checks         = 0;
    int failures       = 0;
    int err_seen       = 0;
    int done_seen      = 0;
    int notready_cyc   = 0;
    logic done_at_accept = 1'b0;
    logic [LOC_SIZE-1:0]   last_x = '0;
    logic [LOC_SIZE-1:0]   last_y = '0;
    logic [PIXEL_SIZE-1:0] last_d = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Output monitor: pops one scoreboard entry per en strobe, checks hold otherwise.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                last_x = '0;
                last_y = '0;
                last_d = '0;
            end else begin
                if (!s_ready) notready_cyc++;
                if (sync_err) err_seen++;
                if (frame_done) begin
                    done_seen++;
                    check_eq("done_err_overlap", 32'(sync_err), 32'd0);
                end
                if (en) begin
                    if (sb.size() == 0) begin
                        check_eq("unexpected_en", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check_eq("x", 32'(x), 32'(e.x));
                        check_eq("y", 32'(y), 32'(e.y));
                        check_eq("data", 32'(data), 32'(e.d));
                        check_eq("frame_done", 32'(frame_done), 32'(e.done));
                        last_x = e.x;
                        last_y = e.y;
                        last_d = e.d;
                    end
                end else begin
                    check_eq("hold_x", 32'(x), 32'(last_x));
                    check_eq("hold_y", 32'(y), 32'(last_y));
                    check_eq("hold_data", 32'(data), 32'(last_d));
                    check_eq("done_without_en", 32'(frame_done), 32'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog sb_left=%0d", sb.size());
        $fatal(1, "watchdog expired");
    end

    task automatic idle(input int n);
        s_valid = 1'b0;
        s_sof   = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer one beat (leaves s_valid high); on acceptance push what it must produce.
    task automatic send_beat(input logic sof, input logic [PIXEL_SIZE-1:0] d, input logic push,
                             input int ex, input int ey, input logic last);
        logic rdy;
        exp_t e;
        rdy     = 1'b0;
        s_valid = 1'b1;
        s_sof   = sof;
        s_data  = d;
        for (int t = 0; t < 64 && !rdy; t++) begin
            @(negedge clk);
            rdy            = s_ready;
            done_at_accept = frame_done;
            @(posedge clk);
            #1;
        end
        if (!rdy) begin
            check_eq("accept_timeout", 32'd0, 32'd1);
        end else begin
            if (push) begin
                e.x = LOC_SIZE'(ex); e.y = LOC_SIZE'(ey); e.d = d; e.done = 1'b0;
                sb.push_back(e);
            end
            if (last) begin
                for (int i = 1; i <= FL; i++) begin
                    e.x = LOC_SIZE'(W - 1); e.y = LOC_SIZE'(H - 1); e.d = '0; e.done = (i == FL);
                    sb.push_back(e);
                end
            end
        end
    endtask

    task automatic send_pixels(input int first, input int count, input int gap, input int base);
        int idx;
        for (int i = 0; i < count; i++) begin
            idx = first + i;
            send_beat(idx == 0, PIXEL_SIZE'(base + idx), 1'b1, idx % W, idx / W, idx == W * H - 1);
            if (gap > 0) idle(gap);
        end
    endtask

    task automatic wait_drain(input string tag);
        for (int t = 0; t < 200 && sb.size() != 0; t++) @(posedge clk);
        #1;
        check_eq(tag, 32'(sb.size()), 32'd0);
        idle(2);
    endtask

    initial begin
        int e0;
        int d0;
        reset_n = 1'b0;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_en", 32'(en), 32'd0);
        check_eq("rst_x", 32'(x), 32'd0);
        check_eq("rst_y", 32'(y), 32'd0);
        check_eq("rst_data", 32'(data), 32'd0);
        check_eq("rst_done", 32'(frame_done), 32'd0);
        check_eq("rst_err", 32'(sync_err), 32'd0);
        check_eq("rst_count", 32'(frame_count), 32'd0);
        check_eq("rst_ready", 32'(s_ready), 32'd1);
        check_eq("rst_busy", 32'(frame_busy), 32'd0);
        reset_n = 1'b1;
        idle(1);

        // 1: back-to-back frame
        notready_cyc = 0;
        send_pixels(0, W * H, 0, 0);
        idle(1);
        wait_drain("t1_drain");
        check_eq("t1_notready", 32'(notready_cyc), 32'(FL));
        check_eq("t1_count", 32'(frame_count), 32'd1);
        check_eq("t1_done", 32'(done_seen), 32'd1);
        check_eq("t1_err", 32'(err_seen), 32'd0);

        // 2: valid toggling every other cycle
        send_pixels(0, W * H, 1, 'h100);
        wait_drain("t2_drain");
        check_eq("t2_count", 32'(frame_count), 32'd2);
        check_eq("t2_done", 32'(done_seen), 32'd2);

        // 3: orphan beats in IDLE, then a proper frame
        e0 = err_seen;
        for (int i = 0; i < 3; i++) send_beat(1'b0, PIXEL_SIZE'('h55 + i), 1'b0, 0, 0, 1'b0);
        send_pixels(0, W * H, 0, 'h200);
        idle(1);
        wait_drain("t3_drain");
        check_eq("t3_err", 32'(err_seen - e0), 32'd3);
        check_eq("t3_count", 32'(frame_count), 32'd3);

        // 4: premature sof on the 7th beat
        e0 = err_seen;
        send_pixels(0, 6, 0, 'h300);
        send_beat(1'b1, PIXEL_SIZE'('h400), 1'b1, 0, 0, 1'b0);
        check_eq("t4_count_unchanged", 32'(frame_count), 32'd3);
        send_pixels(1, W * H - 1, 0, 'h400);
        idle(1);
        wait_drain("t4_drain");
        check_eq("t4_err", 32'(err_seen - e0), 32'd1);
        check_eq("t4_count", 32'(frame_count), 32'd4);

        // 5: reset during the third flush beat
        send_pixels(0, W * H, 0, 'h500);
        s_valid = 1'b0;
        s_sof   = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_eq("t5_flush_en", 32'(en), 32'd1);
        check_eq("t5_flush_data", 32'(data), 32'd0);
        d0 = done_seen;
        reset_n = 1'b0;
        #1;
        check_eq("t5_rst_en", 32'(en), 32'd0);
        check_eq("t5_rst_count", 32'(frame_count), 32'd0);
        check_eq("t5_rst_busy", 32'(frame_busy), 32'd0);
        check_eq("t5_rst_ready", 32'(s_ready), 32'd1);
        sb.delete();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(10);
        check_eq("t5_no_done", 32'(done_seen - d0), 32'd0);
        check_eq("t5_ready", 32'(s_ready), 32'd1);
        check_eq("t5_count", 32'(frame_count), 32'd0);

        // 6: two frames with s_valid held high throughout
        d0 = done_seen;
        send_pixels(0, W * H, 0, 'h600);
        send_beat(1'b1, PIXEL_SIZE'('h700), 1'b1, 0, 0, 1'b0);
        check_eq("t6_sof_with_done", 32'(done_at_accept), 32'd1);
        send_pixels(1, W * H - 1, 0, 'h700);
        idle(1);
        wait_drain("t6_drain");
        check_eq("t6_done", 32'(done_seen - d0), 32'd2);
        check_eq("t6_count", 32'(frame_count), 32'd2);

        check_eq("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
